// File: rtl/driver_complex_multiplier.sv
// Stimulus driver for the complex multiplier: LFSR operands out, results drained in.
// Latency: op_val rises the cycle after SEND is entered; done pulses the cycle after DONE.
// Backpressure: op word held while op_val && !op_ready; in-flight count capped at MAX_OUTSTANDING.
//
// Optional feature macro: DRIVER_BACKPRESSURE_EN (gates res_ready with an 8-bit LFSR).
// Ports:
//   clk, rstn (async, active-low), sw_rst (sync, active-high, highest priority)
//   start / nr_transactions   : launch a run of N operand words (sampled in IDLE)
//   busy / done               : run in progress / one-cycle end-of-run pulse
//   unexpected_res            : sticky, result accepted with nothing outstanding
//   tr_sent / tr_received     : per-run handshake counters
//   op_val / op_ready / op_data    : operand initiator interface {a_re,a_im,b_re,b_im}
//   res_val / res_ready / res_data : result sink interface (data observed only)
module driver_complex_multiplier #(
  parameter int          DATA_WIDTH      = 8,
  parameter int          NR_TR_WIDTH     = 16,
  parameter logic [31:0] LFSR_SEED       = 32'h12345678,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      sw_rst,
  input  logic                      start,
  input  logic [NR_TR_WIDTH-1:0]    nr_transactions,
  output logic                      busy,
  output logic                      done,
  output logic                      unexpected_res,
  output logic [NR_TR_WIDTH-1:0]    tr_sent,
  output logic [NR_TR_WIDTH-1:0]    tr_received,
  output logic                      op_val,
  input  logic                      op_ready,
  output logic [4*DATA_WIDTH-1:0]   op_data,
  input  logic                      res_val,
  output logic                      res_ready,
  input  logic [4*DATA_WIDTH+2:0]   res_data
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0]            SEED   = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [NR_TR_WIDTH-1:0] MAX_OS = NR_TR_WIDTH'(MAX_OUTSTANDING);
  localparam logic [NR_TR_WIDTH-1:0] ONE    = NR_TR_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [NR_TR_WIDTH-1:0] n_q, n_d;
  logic [NR_TR_WIDTH-1:0] tr_sent_q, tr_sent_d;
  logic [NR_TR_WIDTH-1:0] tr_received_q, tr_received_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic                   op_val_q, op_val_d;
  logic                   res_ready_q, res_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   unexpected_q, unexpected_d;
  logic                   op_hs, res_hs;
  logic [NR_TR_WIDTH-1:0] outstanding, outstanding_d;
  logic                   active_d;

`ifdef DRIVER_BACKPRESSURE_EN
  logic [7:0] lfsr8_q, lfsr8_d;
`endif

  // Result data is only observed by the monitor, never by this driver.
  logic unused_res_data;
  assign unused_res_data = ^res_data;

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    tr_sent_d     = tr_sent_q;
    tr_received_d = tr_received_q;
    lfsr_d        = lfsr_q;
    unexpected_d  = unexpected_q;

    op_hs       = op_val_q && op_ready;
    res_hs      = res_val && res_ready_q;
    outstanding = tr_sent_q - tr_received_q;

    if (op_hs) begin
      tr_sent_d = tr_sent_q + ONE;
      lfsr_d    = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    end
    // A result with nothing in flight is flagged rather than counted.
    if (res_hs) begin
      if (outstanding == '0) unexpected_d = 1'b1;
      else                   tr_received_d = tr_received_q + ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d           = nr_transactions;
          tr_sent_d     = '0;
          tr_received_d = '0;
          state_d       = (nr_transactions == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND:  if (op_hs && (tr_sent_d == n_q)) state_d = S_DRAIN;
      S_DRAIN: if (tr_received_d == n_q)        state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Next-cycle counters decide the next op_val, so the cap is never overshot
    // and back-to-back words flow when there is room. A pending word is held.
    outstanding_d = tr_sent_d - tr_received_d;
    op_val_d = (state_q == S_SEND) && (state_d == S_SEND) &&
               ((op_val_q && !op_ready) ||
                ((tr_sent_d < n_q) && (outstanding_d < MAX_OS)));

    active_d = (state_d == S_SEND) || (state_d == S_DRAIN);
    busy_d   = active_d;
    done_d   = (state_q == S_DONE);

`ifdef DRIVER_BACKPRESSURE_EN
    lfsr8_d     = {lfsr8_q[6:0], lfsr8_q[7] ^ lfsr8_q[5] ^ lfsr8_q[4] ^ lfsr8_q[3]};
    res_ready_d = active_d && lfsr8_d[0];
`else
    res_ready_d = active_d;
`endif

    // Soft reset overrides everything, including an in-flight run.
    if (sw_rst) begin
      state_d       = S_IDLE;
      n_d           = '0;
      tr_sent_d     = '0;
      tr_received_d = '0;
      lfsr_d        = SEED;
      unexpected_d  = 1'b0;
      op_val_d      = 1'b0;
      res_ready_d   = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
`ifdef DRIVER_BACKPRESSURE_EN
      lfsr8_d       = 8'hA5;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      tr_sent_q     <= '0;
      tr_received_q <= '0;
      lfsr_q        <= SEED;
      unexpected_q  <= 1'b0;
      op_val_q      <= 1'b0;
      res_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef DRIVER_BACKPRESSURE_EN
      lfsr8_q       <= 8'hA5;
`endif
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      tr_sent_q     <= tr_sent_d;
      tr_received_q <= tr_received_d;
      lfsr_q        <= lfsr_d;
      unexpected_q  <= unexpected_d;
      op_val_q      <= op_val_d;
      res_ready_q   <= res_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef DRIVER_BACKPRESSURE_EN
      lfsr8_q       <= lfsr8_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign unexpected_res = unexpected_q;
  assign tr_sent        = tr_sent_q;
  assign tr_received    = tr_received_q;
  assign op_val         = op_val_q;
  assign op_data        = lfsr_q[4*DATA_WIDTH-1:0];
  assign res_ready      = res_ready_q;

endmodule

// File: tb/tb_driver_complex_multiplier.sv
// Bench for driver_complex_multiplier: plays the multiplier (3-cycle result latency)
// and scoreboards operand words against an independent LFSR reference.
// Inputs change only at posedge+1; outputs are sampled there too.
module tb_driver_complex_multiplier;

  localparam int          DW   = 8;
  localparam int          NW   = 16;
  localparam int          LAT  = 3;
  localparam logic [31:0] SEED = 32'h12345678;

  logic          clk = 1'b0;
  logic          rstn, sw_rst, start;
  logic [NW-1:0] nr_transactions;
  logic          busy, done, unexpected_res;
  logic [NW-1:0] tr_sent, tr_received;
  logic          op_val, op_ready;
  logic [4*DW-1:0] op_data;
  logic          res_val, res_ready;
  logic [4*DW+2:0] res_data;

  driver_complex_multiplier #(
    .DATA_WIDTH(DW), .NR_TR_WIDTH(NW), .LFSR_SEED(SEED), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .start(start),
    .nr_transactions(nr_transactions), .busy(busy), .done(done),
    .unexpected_res(unexpected_res), .tr_sent(tr_sent), .tr_received(tr_received),
    .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
    .res_val(res_val), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cycle  = 0;
  int          done_cnt = 0;
  int          max_os = 0;
  bit          resp_en = 0;
  logic [31:0] m_lfsr = SEED;
  logic [31:0] exp_q[$];   // expected operand words, in order
  int          lat_q[$];   // due cycle of each pending result

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_lfsr);
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED;
    exp_q.delete();
    lat_q.delete();
  endtask

  // One clock cycle: account for handshakes about to happen, then advance.
  task automatic step();
    bit ohs, rhs;
    int os;
    ohs = op_val && op_ready;
    rhs = res_val && res_ready;
    if (ohs) begin
      chk("op_sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("op_data_sb", op_data, exp_q.pop_front());
      lat_q.push_back(cycle + LAT);
    end
    if (rhs && lat_q.size() != 0) void'(lat_q.pop_front());
    @(posedge clk); #1;
    cycle++;
    if (done) done_cnt++;
    os = int'(tr_sent) - int'(tr_received);
    if (os > max_os) max_os = os;
    if (resp_en) begin
      res_val  = (lat_q.size() != 0) && (lat_q[0] <= cycle);
      res_data = 35'($urandom);
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    bit seen = 0;
    while (!seen && k < budget) begin
      step();
      k++;
      if (done) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic hard_reset();
    rstn = 1'b0; start = 1'b0; sw_rst = 1'b0; op_ready = 1'b0;
    res_val = 1'b0; resp_en = 0; nr_transactions = '0;
    @(posedge clk); #1;
    model_reset();
    rstn = 1'b1;
    done_cnt = 0;
    max_os = 0;
  endtask

  task automatic launch(input int n);
    nr_transactions = NW'(n);
    push_words(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    bit bad;
    int k;
    rstn = 1'b0; sw_rst = 1'b0; start = 1'b0; op_ready = 1'b0;
    res_val = 1'b0; nr_transactions = '0; res_data = '0;

    // 1: reset values, then quiet idle with no start
    #12;
    chk("rst_op_val",    32'(op_val),    32'd0);
    chk("rst_res_ready", 32'(res_ready), 32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_tr_sent",   32'(tr_sent),   32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (op_val || res_ready || done || busy || unexpected_res ||
          tr_sent != '0 || tr_received != '0) bad = 1;
    end
    chk("idle_stable", 32'(bad), 32'd0);
    chk("idle_op_data", op_data, 32'h12345678);

    // 2: N=2, always ready, 3-cycle result latency
    done_cnt = 0;
    op_ready = 1'b1;
    resp_en  = 1;
    launch(2);
    chk("t2_busy",        32'(busy),   32'd1);
    chk("t2_op_val_late", 32'(op_val), 32'd0);
    step();
    chk("t2_op_val",  32'(op_val), 32'd1);
    chk("t2_word0",   op_data,     32'h12345678);
    step();
    chk("t2_word1",   op_data,     32'h2468ACF1);
    wait_done(50, "t2");
    chk("t2_tr_sent", 32'(tr_sent),     32'd2);
    chk("t2_tr_rcv",  32'(tr_received), 32'd2);
    for (int i = 0; i < 3; i++) step();
    chk("t2_done_once", 32'(done_cnt), 32'd1);
    chk("t2_busy_end",  32'(busy),     32'd0);

    // 3: operand stall holds the word
    hard_reset();
    resp_en = 1;
    launch(8);
    step();
    chk("t3_op_val", 32'(op_val), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_data", op_data, 32'h12345678);
      step();
    end
    chk("t3_tr_sent_0", 32'(tr_sent), 32'd0);
    op_ready = 1'b1;
    wait_done(200, "t3");
    chk("t3_tr_rcv",  32'(tr_received), 32'd8);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: results withheld -> in-flight cap, then one word per returned result
    hard_reset();
    op_ready = 1'b1;
    launch(10);
    for (int i = 0; i < 20; i++) step();
    chk("t4_cap_sent",   32'(tr_sent), 32'd4);
    chk("t4_cap_op_val", 32'(op_val),  32'd0);
    chk("t4_max_os",     32'(max_os),  32'd4);
    res_val = 1'b1;
    step();
    res_val = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t4_resume_sent", 32'(tr_sent),     32'd5);
    chk("t4_resume_rcv",  32'(tr_received), 32'd1);
    chk("t4_resume_stop", 32'(op_val),      32'd0);
    resp_en = 1;
    res_val = (lat_q.size() != 0);
    wait_done(300, "t4");
    chk("t4_tr_rcv",   32'(tr_received), 32'd10);
    chk("t4_max_os_end", 32'(max_os),    32'd4);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: N=0 run, then a start ignored during a busy run
    hard_reset();
    bad = 0;
    launch(0);
    if (op_val) bad = 1;
    chk("t5_done_early", 32'(done), 32'd0);
    step();
    if (op_val) bad = 1;
    chk("t5_done_2cyc", 32'(done), 32'd1);
    step();
    if (op_val) bad = 1;
    chk("t5_done_1pulse", 32'(done),  32'd0);
    chk("t5_no_op_val",   32'(bad),   32'd0);
    op_ready = 1'b1;
    resp_en  = 1;
    launch(3);
    step();
    chk("t5_busy", 32'(busy), 32'd1);
    nr_transactions = NW'(7);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100, "t5");
    chk("t5_n_kept_sent", 32'(tr_sent),     32'd3);
    chk("t5_n_kept_rcv",  32'(tr_received), 32'd3);

    // 6: soft reset mid-run, then a result with nothing outstanding
    hard_reset();
    op_ready = 1'b1;
    launch(8);
    k = 0;
    while (tr_sent != NW'(3) && k < 20) begin
      step();
      k++;
    end
    chk("t6_reach3", 32'(tr_sent), 32'd3);
    sw_rst   = 1'b1;
    op_ready = 1'b0;
    step();
    sw_rst = 1'b0;
    model_reset();
    chk("t6_busy",      32'(busy),        32'd0);
    chk("t6_op_val",    32'(op_val),      32'd0);
    chk("t6_tr_sent",   32'(tr_sent),     32'd0);
    chk("t6_tr_rcv",    32'(tr_received), 32'd0);
    chk("t6_res_ready", 32'(res_ready),   32'd0);
    launch(2);
    chk("t6_unexp_clear", 32'(unexpected_res), 32'd0);
    res_val = 1'b1;
    step();
    res_val = 1'b0;
    chk("t6_unexp_set", 32'(unexpected_res), 32'd1);
    chk("t6_unexp_rcv", 32'(tr_received),    32'd0);
    chk("t6_reseeded",  op_data,             32'h12345678);
    for (int i = 0; i < 3; i++) step();
    chk("t6_unexp_sticky", 32'(unexpected_res), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
